// File: rtl/cpu_pkg.sv
// Shared widths, the bubble encoding and the IF/ID register layout for the LEGv8 pipeline.
package cpu_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

  // Contents of IF/ID whenever it does not hold a real instruction.
  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous reset to a fixed address, loads only when enabled.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] d_i,
  output logic [ADDR_W-1:0] q_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// LEGv8 fetch stage: PC, next-PC selection, IF/ID capture, sticky misaligned-redirect fault
// and a count of instructions delivered into IF/ID.
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               fetch_fault,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              pc_load;
  if_id_t            if_id_q;
  if_id_t            if_id_d;
  logic              fault_q;
  logic              fault_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load_i(pc_load),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  // Priority: fault > redirect > stall > normal fetch; reset is applied in the registers.
  always_comb begin
    pc_d    = pc_q;
    pc_load = 1'b0;
    if_id_d = if_id_q;
    fault_d = fault_q;
    count_d = count_q;
    if (fault_q) begin
      if_id_d = IF_ID_BUBBLE;
    end else if (redirect) begin
      if_id_d = IF_ID_BUBBLE;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end else begin
        pc_d    = redirect_pc;
        pc_load = 1'b1;
      end
    end else if (!stall) begin
      if_id_d = '{pc: pc_q, instr: imem_data, valid: 1'b1};
      pc_d    = pc_q + ADDR_W'(4);
      pc_load = 1'b1;
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_q <= IF_ID_BUBBLE;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      if_id_q <= if_id_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_valid = if_id_q.valid;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scenario bench for instr_fetch_stage: expected observations are queued as stimulus is
// applied and compared against the outputs one time unit after the following clock edge.
module tb_instr_fetch_stage;

  localparam logic [31:0] BASE = 32'h8B020020;
  localparam logic [31:0] NOP  = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic [31:0] count;
  } obs_t;

  obs_t sb[$];
  obs_t exp_o;
  obs_t got_o;
  int   total = 0;
  int   bad = 0;

  instr_fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_valid(if_id_valid),
    .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory model: every word reads as BASE plus its own address.
  assign imem_data = BASE + imem_addr[31:0];

  function automatic obs_t mk(logic [63:0] addr, logic [63:0] pc, logic [31:0] instr,
                              logic valid, logic fault, logic [31:0] count);
    obs_t o;
    o = '{addr: addr, pc: pc, instr: instr, valid: valid, fault: fault, count: count};
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_fault, fetch_count);
  endfunction

  task automatic drive(logic r, logic s, logic rd, logic [63:0] rpc);
    reset       = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_reset();
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    sb.push_back(mk(64'h0, 64'h0, NOP, 1'b0, 1'b0, 32'd0));
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    exp_o = sb.pop_front();
    got_o = sample();
    total++;
    if (got_o !== exp_o) begin
      bad++;
      $display("FAIL reset: got %h required %h", got_o, exp_o);
    end
    $display("reset: addr=%h pc=%h instr=%h valid=%b fault=%b count=%0d",
             got_o.addr, got_o.pc, got_o.instr, got_o.valid, got_o.fault, got_o.count);
  endtask

  task automatic test_fetch();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      sb.push_back(mk(64'(4 * k), 64'(4 * (k - 1)), BASE + 32'(4 * (k - 1)), 1'b1, 1'b0, 32'(k)));
      tick();
      exp_o = sb.pop_front();
      got_o = sample();
      total++;
      if (got_o !== exp_o) begin
        bad++;
        $display("FAIL fetch%0d: got %h required %h", k, got_o, exp_o);
      end
      $display("fetch%0d: if_id_pc=%h instr=%h count=%0d", k, got_o.pc, got_o.instr, got_o.count);
    end
  endtask

  task automatic test_stall();
    quiet_reset();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 64'h0);
      sb.push_back(mk(64'h8, 64'h4, BASE + 32'h4, 1'b1, 1'b0, 32'd2));
      tick();
      exp_o = sb.pop_front();
      got_o = sample();
      total++;
      if (got_o !== exp_o) begin
        bad++;
        $display("FAIL stall%0d: got %h required %h", k, got_o, exp_o);
      end
      $display("stall%0d: addr=%h if_id_pc=%h count=%0d", k, got_o.addr, got_o.pc, got_o.count);
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    sb.push_back(mk(64'hC, 64'h8, BASE + 32'h8, 1'b1, 1'b0, 32'd3));
    tick();
    exp_o = sb.pop_front();
    got_o = sample();
    total++;
    if (got_o !== exp_o) begin
      bad++;
      $display("FAIL stall_release: got %h required %h", got_o, exp_o);
    end
    $display("stall_release: if_id_pc=%h count=%0d", got_o.pc, got_o.count);
  endtask

  // Continues from test_stall: pc=0xC, count=3.
  task automatic test_redirect();
    drive(1'b0, 1'b1, 1'b1, 64'h40);
    sb.push_back(mk(64'h40, 64'h0, NOP, 1'b0, 1'b0, 32'd3));
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    sb.push_back(mk(64'h44, 64'h40, BASE + 32'h40, 1'b1, 1'b0, 32'd4));
    for (int k = 0; k < 2; k++) begin
      exp_o = sb.pop_front();
      got_o = sample();
      total++;
      if (got_o !== exp_o) begin
        bad++;
        $display("FAIL redirect%0d: got %h required %h", k, got_o, exp_o);
      end
      $display("redirect%0d: addr=%h if_id_pc=%h valid=%b", k, got_o.addr, got_o.pc, got_o.valid);
      if (k == 0) tick();
    end
  endtask

  // Continues from test_redirect: pc=0x44, count=4.
  task automatic test_fault();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0:       drive(1'b0, 1'b0, 1'b1, 64'h42);
        1:       drive(1'b0, 1'b0, 1'b1, 64'h80);
        2:       drive(1'b0, 1'b1, 1'b0, 64'h0);
        default: drive(1'b0, 1'b0, 1'b0, 64'h0);
      endcase
      sb.push_back(mk(64'h44, 64'h0, NOP, 1'b0, 1'b1, 32'd4));
      tick();
      exp_o = sb.pop_front();
      got_o = sample();
      total++;
      if (got_o !== exp_o) begin
        bad++;
        $display("FAIL fault%0d: got %h required %h", k, got_o, exp_o);
      end
      $display("fault%0d: addr=%h valid=%b fault=%b", k, got_o.addr, got_o.valid, got_o.fault);
    end
    drive(1'b1, 1'b0, 1'b1, 64'h42);
    sb.push_back(mk(64'h0, 64'h0, NOP, 1'b0, 1'b0, 32'd0));
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    exp_o = sb.pop_front();
    got_o = sample();
    total++;
    if (got_o !== exp_o) begin
      bad++;
      $display("FAIL fault_clear: got %h required %h", got_o, exp_o);
    end
    $display("fault_clear: fault=%b count=%0d", got_o.fault, got_o.count);
  endtask

  // Starts from reset state (pc=0, count=0).
  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    sb.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, NOP, 1'b0, 1'b0, 32'd0));
    tick();
    exp_o = sb.pop_front();
    got_o = sample();
    total++;
    if (got_o !== exp_o) begin
      bad++;
      $display("FAIL wrap_redirect: got %h required %h", got_o, exp_o);
    end
    $display("wrap_redirect: addr=%h", got_o.addr);
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    sb.push_back(mk(64'h0, 64'hFFFF_FFFF_FFFF_FFFC, BASE + 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd1));
    sb.push_back(mk(64'h4, 64'h0, BASE, 1'b1, 1'b0, 32'd2));
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_o = sb.pop_front();
      got_o = sample();
      total++;
      if (got_o !== exp_o) begin
        bad++;
        $display("FAIL wrap%0d: got %h required %h", k, got_o, exp_o);
      end
      $display("wrap%0d: addr=%h if_id_pc=%h fault=%b count=%0d",
               k, got_o.addr, got_o.pc, got_o.fault, got_o.count);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b1, 64'h100);
    sb.push_back(mk(64'h0, 64'h0, NOP, 1'b0, 1'b0, 32'd0));
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    sb.push_back(mk(64'h4, 64'h0, BASE, 1'b1, 1'b0, 32'd1));
    for (int k = 0; k < 2; k++) begin
      exp_o = sb.pop_front();
      got_o = sample();
      total++;
      if (got_o !== exp_o) begin
        bad++;
        $display("FAIL reset_mid%0d: got %h required %h", k, got_o, exp_o);
      end
      $display("reset_mid%0d: addr=%h if_id_pc=%h valid=%b count=%0d",
               k, got_o.addr, got_o.pc, got_o.valid, got_o.count);
      if (k == 0) tick();
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_fault();
    test_wrap();
    test_reset_mid();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
